// File: rtl/block_ram_be_pkg.sv
// Shared types and helpers for the byte-strobed block RAM.
// byte_merge works on MERGE_W-bit words; callers size-cast to and from their own WIDTH.
package block_ram_pkg;

    localparam int MIN_LAT = 1;
    localparam int MAX_LAT = 2;
    localparam int MERGE_W = 1024;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } block_ram_state_t;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]   old_word,
        input logic [MERGE_W-1:0]   new_word,
        input logic [MERGE_W/8-1:0] strobe
    );
        logic [MERGE_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MERGE_W / 8; b++) begin
            if (strobe[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/block_ram_be.sv
// Dual-port (1W/1R) block RAM with byte strobes, 1/2-cycle read latency and a post-reset clear.
// Define BLOCK_RAM_BE_WRITE_FIRST_EN to return the merged word on a same-address read/write.
module block_ram_be
    import block_ram_pkg::*;
#(
    parameter int SIZE         = 1024,
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 1,
    localparam int BYTES       = WIDTH / 8,
    localparam int DEPTH       = SIZE / BYTES,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             ready,
    input  logic             write_en,
    input  logic [BYTES-1:0] write_strobe,
    input  logic [AW-1:0]    write_address,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_en,
    input  logic [AW-1:0]    read_address,
    output logic [WIDTH-1:0] read_data,
    output logic             read_valid
);

    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_bad_width
        $error("block_ram_be: WIDTH must be >= 8 and a multiple of 8");
    end
    if ((SIZE % BYTES) != 0) begin : g_bad_size
        $error("block_ram_be: SIZE must be a multiple of WIDTH/8");
    end
    if (READ_LATENCY < MIN_LAT || READ_LATENCY > MAX_LAT) begin : g_bad_lat
        $error("block_ram_be: READ_LATENCY must be 1 or 2");
    end

    block_ram_state_t state_q, state_d;
    logic [AW-1:0]    clear_addr_q, clear_addr_d;

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        if (state_q == CLEAR) begin
            clear_addr_d = clear_addr_q + AW'(1);
            if (clear_addr_q == LAST_ADDR) begin
                state_d      = READY;
                clear_addr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CLEAR;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    assign ready = (state_q == READY);

    logic wr_in_range, rd_in_range, wr_accept, rd_accept;

    assign wr_in_range = ({1'b0, write_address} < DEPTH_W);
    assign rd_in_range = ({1'b0, read_address} < DEPTH_W);
    assign wr_accept   = ready && write_en && wr_in_range;
    assign rd_accept   = ready && read_en;

    // The clear sequencer borrows the write port as a full-word zero write.
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [BYTES-1:0] mem_be;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = write_address;
        mem_wdata = write_data;
        mem_be    = write_strobe;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = clear_addr_q;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (wr_accept) begin
            mem_we = 1'b1;
        end
    end

    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mem_be[b]) begin
                    mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    logic [WIDTH-1:0] rd_word_q;
    logic             rd_valid_q;
    logic [WIDTH-1:0] rd_merged;

`ifdef BLOCK_RAM_BE_WRITE_FIRST_EN
    logic             hit_q;
    logic [WIDTH-1:0] hit_data_q;
    logic [BYTES-1:0] hit_be_q;
    logic             collision;

    assign collision = wr_accept && (write_address == read_address);
`endif

    // Array read register; holds between reads so read_data holds too.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_word_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef BLOCK_RAM_BE_WRITE_FIRST_EN
            hit_q      <= 1'b0;
            hit_data_q <= '0;
            hit_be_q   <= '0;
`endif
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_word_q  <= rd_in_range ? mem[read_address] : '0;
`ifdef BLOCK_RAM_BE_WRITE_FIRST_EN
                hit_q      <= collision;
                hit_data_q <= write_data;
                hit_be_q   <= write_strobe;
`endif
            end
        end
    end

`ifdef BLOCK_RAM_BE_WRITE_FIRST_EN
    // rd_word_q holds the pre-write word, so merging the captured write gives the post-write word.
    assign rd_merged = hit_q
        ? WIDTH'(byte_merge(MERGE_W'(rd_word_q), MERGE_W'(hit_data_q), (MERGE_W / 8)'(hit_be_q)))
        : rd_word_q;
`else
    assign rd_merged = rd_word_q;
`endif

    if (READ_LATENCY == MIN_LAT) begin : g_lat1
        assign read_data  = rd_merged;
        assign read_valid = rd_valid_q;
    end else begin : g_lat2
        logic [WIDTH-1:0] out_data_q;
        logic             out_valid_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= rd_valid_q;
                if (rd_valid_q) begin
                    out_data_q <= rd_merged;
                end
            end
        end

        assign read_data  = out_data_q;
        assign read_valid = out_valid_q;
    end

endmodule

// File: tb/tb_block_ram_be.sv
// Randomised bench for block_ram_be: one DUT per read latency, shared stimulus, behavioural model.
module tb_block_ram_be;

    localparam int SIZE  = 64;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

`ifdef BLOCK_RAM_BE_WRITE_FIRST_EN
    localparam logic [31:0] COLL_EXP = 32'h1111_1122;
`else
    localparam logic [31:0] COLL_EXP = 32'h1111_1111;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_en = 1'b0;
    logic [3:0]  write_strobe = '0;
    logic [3:0]  write_address = '0;
    logic [31:0] write_data = '0;
    logic        read_en = 1'b0;
    logic [3:0]  read_address = '0;

    logic        ready1, ready2, read_valid1, read_valid2;
    logic [31:0] read_data1, read_data2;

    always #5 clk = ~clk;

    block_ram_be #(.SIZE(SIZE), .WIDTH(WIDTH), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .ready(ready1),
        .write_en(write_en), .write_strobe(write_strobe), .write_address(write_address),
        .write_data(write_data), .read_en(read_en), .read_address(read_address),
        .read_data(read_data1), .read_valid(read_valid1)
    );

    block_ram_be #(.SIZE(SIZE), .WIDTH(WIDTH), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .ready(ready2),
        .write_en(write_en), .write_strobe(write_strobe), .write_address(write_address),
        .write_data(write_data), .read_en(read_en), .read_address(read_address),
        .read_data(read_data2), .read_valid(read_valid2)
    );

    // Model: memory image, cycles since reset release, and per-latency queues of due results.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] ref_mem [DEPTH];
    rd_t         q1[$];
    rd_t         q2[$];
    int          cyc = 0;
    int          clr_cnt = 0;
    logic [31:0] hold1 = '0, hold2 = '0;
    logic [31:0] last1 = '0, last2 = '0;
    int          pulses1 = 0, pulses2 = 0;
    int          errors = 0, checks = 0;

    initial begin : model
        logic [31:0] d;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset !== 1'b1) begin
                clr_cnt = 0;
            end else if (clr_cnt < DEPTH) begin
                clr_cnt++;
                if (clr_cnt == DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
                end
            end else begin
                if (read_en) begin
                    d = ref_mem[read_address];
`ifdef BLOCK_RAM_BE_WRITE_FIRST_EN
                    if (write_en && write_address == read_address) begin
                        for (int b = 0; b < 4; b++)
                            if (write_strobe[b]) d[8*b +: 8] = write_data[8*b +: 8];
                    end
`endif
                    q1.push_back('{due: cyc, data: d});
                    q2.push_back('{due: cyc + 1, data: d});
                end
                if (write_en) begin
                    for (int b = 0; b < 4; b++)
                        if (write_strobe[b]) ref_mem[write_address][8*b +: 8] = write_data[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic ev1, ev2, exp_ready;
        ev1 = 1'b0;
        ev2 = 1'b0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            ev1 = 1'b1; hold1 = q1[0].data; void'(q1.pop_front());
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
            ev2 = 1'b1; hold2 = q2[0].data; void'(q2.pop_front());
        end
        exp_ready = (reset === 1'b1) && (clr_cnt == DEPTH);
        chk("ready_lat1", 32'(ready1), 32'(exp_ready));
        chk("ready_lat2", 32'(ready2), 32'(exp_ready));
        chk("valid_lat1", 32'(read_valid1), 32'(ev1));
        chk("valid_lat2", 32'(read_valid2), 32'(ev2));
        chk("data_lat1", read_data1, hold1);
        chk("data_lat2", read_data2, hold2);
        if (read_valid1 === 1'b1) begin last1 = read_data1; pulses1++; end
        if (read_valid2 === 1'b1) begin last2 = read_data2; pulses2++; end
        $display("cyc=%0d rst=%b we=%b wa=%0d ws=%h wd=%h re=%b ra=%0d | rdy=%b v1=%b d1=%h v2=%b d2=%h",
                 cyc, reset, write_en, write_address, write_strobe, write_data, read_en, read_address,
                 ready1, read_valid1, read_data1, read_valid2, read_data2);
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
    endtask

    task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic re, input logic [3:0] ra);
        write_en = we; write_address = wa; write_data = wd; write_strobe = ws;
        read_en = re; read_address = ra;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        q1.delete();
        q2.delete();
        hold1 = '0;
        hold2 = '0;
        #1;
        chk("rst_ready", 32'(ready1 | ready2), 32'd0);
        chk("rst_valid1", 32'(read_valid1), 32'd0);
        chk("rst_valid2", 32'(read_valid2), 32'd0);
        chk("rst_data1", read_data1, 32'd0);
        chk("rst_data2", read_data2, 32'd0);
    endtask

    // Junk requests are driven throughout the clear; they must have no effect.
    task automatic release_and_clear(input string name);
        int cnt;
        int p2;
        reset = 1'b1;
        cnt = 0;
        p2 = pulses1 + pulses2;
        do begin
            write_en = 1'b1; write_address = 4'($urandom_range(0, 15));
            write_data = $urandom; write_strobe = 4'hF;
            read_en = 1'b1; read_address = 4'($urandom_range(0, 15));
            cycle();
            cnt++;
        end while (ready1 !== 1'b1 && cnt < 40);
        chk(name, 32'(cnt), 32'd16);
        chk({name, "_pulses"}, 32'(pulses1 + pulses2 - p2), 32'd0);
    endtask

    initial begin : driver
        int p1, p2;
        logic [3:0] wa;
        #1;
        assert_reset();
        repeat (3) cycle();
        release_and_clear("clear_cycles");

        // Entire array reads zero after clear.
        p1 = pulses1; p2 = pulses2;
        last1 = 32'hFFFF_FFFF; last2 = 32'hFFFF_FFFF;
        for (int a = 0; a < DEPTH; a++) step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(a));
        idle(3);
        chk("zero_pulses1", 32'(pulses1 - p1), 32'd16);
        chk("zero_pulses2", 32'(pulses2 - p2), 32'd16);
        chk("zero_last1", last1, 32'd0);
        chk("zero_last2", last2, 32'd0);

        // Byte strobes.
        step(1'b1, 4'd5, 32'hDEAD_BEEF, 4'b1111, 1'b0, 4'd0);
        step(1'b1, 4'd5, 32'h0000_AA00, 4'b0010, 1'b0, 4'd0);
        step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd5);
        idle(3);
        chk("strobe_lat1", last1, 32'hDEAD_AAEF);
        chk("strobe_lat2", last2, 32'hDEAD_AAEF);

        // Back-to-back reads: latency 1 and 2 timing.
        step(1'b1, 4'd1, 32'hA1A1_A1A1, 4'hF, 1'b0, 4'd0);
        step(1'b1, 4'd2, 32'hB2B2_B2B2, 4'hF, 1'b0, 4'd0);
        step(1'b1, 4'd3, 32'hC3C3_C3C3, 4'hF, 1'b0, 4'd0);
        step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd1);
        chk("b2b_n0_v1", 32'(read_valid1), 32'd1);
        chk("b2b_n0_d1", read_data1, 32'hA1A1_A1A1);
        chk("b2b_n0_v2", 32'(read_valid2), 32'd0);
        step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2);
        chk("b2b_n1_v2", 32'(read_valid2), 32'd1);
        chk("b2b_n1_d2", read_data2, 32'hA1A1_A1A1);
        step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3);
        chk("b2b_n2_d2", read_data2, 32'hB2B2_B2B2);
        idle(1);
        chk("b2b_n3_v2", 32'(read_valid2), 32'd1);
        chk("b2b_n3_d2", read_data2, 32'hC3C3_C3C3);
        idle(1);
        chk("b2b_n4_v2", 32'(read_valid2), 32'd0);
        chk("b2b_n4_hold", read_data2, 32'hC3C3_C3C3);

        // Same-address collision.
        step(1'b1, 4'd7, 32'h1111_1111, 4'hF, 1'b0, 4'd0);
        step(1'b1, 4'd7, 32'h2222_2222, 4'b0001, 1'b1, 4'd7);
        idle(3);
        chk("coll_lat1", last1, COLL_EXP);
        chk("coll_lat2", last2, COLL_EXP);

        // Reset while a latency-2 read is in flight; clear must restart from address 0.
        step(1'b1, 4'd0, 32'h5555_5555, 4'hF, 1'b0, 4'd0);
        step(1'b1, 4'd15, 32'h6666_6666, 4'hF, 1'b0, 4'd0);
        step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd15);
        assert_reset();
        idle(2);
        release_and_clear("reclear_cycles");
        p2 = pulses2;
        step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd15);
        step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd0);
        idle(3);
        chk("reclear_pulses2", 32'(pulses2 - p2), 32'd2);
        chk("reclear_addr0", last2, 32'd0);

        // Random traffic with frequent collisions.
        for (int i = 0; i < 800; i++) begin
            wa = 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_ram_be.md
Name: block_ram_be

Overview:
- Parametrised successor to the team's simple synchronous RAM.
- Separate read and write ports, per-byte write strobes, and selectable 1- or 2-cycle read latency.
- Read requests are qualified by `read_valid`.
- After reset, a built-in clear sequencer zeroes the whole array and signals `ready`.
- Used as instruction/data scratchpad and register-file backing store in the core.

Parameters:
- SIZE, 1024, total memory size in bytes.
- WIDTH, 32, word width in bits; must be ≥8 and divisible by 8.
- READ_LATENCY, 1, cycles from accepted read to `read_valid`; legal values 1 or 2.
- Derived: BYTES = WIDTH/8; DEPTH = SIZE/BYTES; AW = $clog2(DEPTH).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset; low clears outputs and restarts the clear sequence.
- ready  output  1  high once the array clear has finished; requests are accepted only while high.
- write_en  input  1  write request.
- write_strobe  input  BYTES  per-byte write enable; bit i covers write_data[8i+7:8i].
- write_address  input  AW  word address for the write.
- write_data  input  WIDTH  write data.
- read_en  input  1  read request.
- read_address  input  AW  word address for the read.
- read_data  output  WIDTH  read result; holds its last value between reads.
- read_valid  output  1  one-cycle pulse marking read_data as new.

Behaviour:
- Reset asserted (reset low, asynchronous):
  - ready=0, read_valid=0, read_data=0.
  - Latency pipeline flushed; FSM forced to CLEAR; clear_addr=0.
  - Array contents are not touched asynchronously.
- FSM states: CLEAR, READY.
  - CLEAR: each clock writes all-zero to memory[clear_addr] and increments clear_addr.
  - At clear_addr==DEPTH-1, transitions to READY; ready rises on the next cycle.
  - Clear takes DEPTH cycles after reset deassertion.
  - READY: stays until reset; no other exit.
- While ready=0:
  - write_en and read_en are ignored; no write occurs and no read_valid is produced.
- Write (ready=1, write_en=1): bytes with strobe=1 update at the edge; other bytes keep their value. All-zero strobe is a no-op.
- Read (ready=1, read_en=1), READ_LATENCY=1:
  - Array read at edge N; read_data/read_valid at edge N.
  - Visible in cycle N+1.
- Read, READ_LATENCY=2:
  - Extra output register stage.
  - Valid in cycle N+2.
  - Back-to-back reads are fully pipelined at one per cycle.
- read_valid is high for exactly one cycle per accepted read; read_data changes only when read_valid is produced.
- Address out of range (address ≥ DEPTH, possible only when DEPTH is not a power of two):
  - Write: dropped.
  - Read: returns 0 with read_valid=1.
- Same-address read and write in the same cycle: read-first (old word) by default; see Optional Feature.
- Reset low mid-pipeline: in-flight reads are discarded, with no read_valid after reset release until a new accepted read.
- Parameter checks in an initial block via ASSERT:
  - WIDTH ≥ 8 and WIDTH%8==0.
  - SIZE%BYTES==0.
  - READ_LATENCY ∈ {1,2}.

Optional Feature:
- Macro BLOCK_RAM_BE_WRITE_FIRST_EN.
- Defined: a collision returns the merged word: strobed bytes from write_data, unstrobed bytes from the old memory word. The merge is done on a bypass path and is valid at the same latency.
- Undefined: a collision returns the old word (read-first). No bypass logic is synthesised.

Decomposition:
- Package `block_ram_pkg`:
  - State enum `block_ram_state_t` {CLEAR, READY}.
  - Function `byte_merge(old, new, strobe)`, parametrised via WIDTH.
  - Latency constants MIN_LAT=1 and MAX_LAT=2.
- No sub-module; the memory array carries the `(* ram_style = "block" *)` attribute, with a single always block per concern: FSM, write, read pipeline.

Test Plan:
- SIZE=64, WIDTH=32: hold reset low 3 cycles, release → ready low for exactly 16 cycles then high; read of every address returns 0x00000000.
- Write 0xDEADBEEF to addr 5 with strobe 4'b1111, then strobe 4'b0010 with data 0x0000AA00 → read addr 5 returns 0xDEADAAEF.
- READ_LATENCY=2, reads to addrs 1,2,3 on consecutive cycles → read_valid high on cycles N+2, N+3, N+4 with the matching data; read_data stable between pulses.
- Addr 7 holds 0x11111111; write 0x22222222 (strobe 4'b0001) and read addr 7 in the same cycle → 0x11111111 without the macro, 0x11111122 with BLOCK_RAM_BE_WRITE_FIRST_EN.
- Write/read requests issued while ready=0 → no memory change, no read_valid; addr 0 still reads 0 after clear.
- Pull reset low while a 2-cycle read is in flight → read_valid=0 and read_data=0 immediately; no stale pulse after release; clear sequence restarts from address 0.
